// File: rtl/sa_fifo_flowctl_64x18_pkg.sv
// Shared sizing and types for the 64x18 flow-controlled FIFO and its RAM.
package sa_fifo_flowctl_64x18_pkg;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 18;
  localparam int unsigned OW    = AW + 1;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [OW-1:0] occ_t;

endpackage

// File: rtl/sa_fifo_flowctl_64x18_if.sv
// Producer/consumer stream bundle for the FIFO. master = stream driver and sink,
// slave = the FIFO itself.
interface sa_fifo_flowctl_64x18_if;
  import sa_fifo_flowctl_64x18_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  out_valid;
  logic  out_ready;
  data_t out_data;
  occ_t  occ;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );

endinterface

// File: rtl/sa_ram_rws_64x18.sv
// 64x18 RAM, one write port and one read port with a registered read address.
// dout follows the captured address, so a write and an address capture on the
// same edge make the new word visible on the next cycle.
module sa_ram_rws_64x18
  import sa_fifo_flowctl_64x18_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  ptr_t        wa,
  input  data_t       di,
  input  logic        re,
  input  ptr_t        ra,
  output data_t       dout,
  input  logic [31:0] pwrbus_ram_pd
);

  data_t mem [DEPTH];
  ptr_t  ra_q;

  // Power-control bus has no behavioural effect in this model.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Write the array and capture the read address; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_q <= ra;
  end

  assign dout = mem[ra_q];

endmodule

// File: rtl/sa_fifo_flowctl_64x18.sv
// First-word-fall-through FIFO built around the registered-address RAM.
// The head word sits on RAM dout; its slot stays counted in occ until popped,
// so it can never be overwritten while the consumer stalls.
module sa_fifo_flowctl_64x18
  import sa_fifo_flowctl_64x18_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  sa_fifo_flowctl_64x18_if.slave   bus,
  input  logic [31:0]              pwrbus_ram_pd
);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  occ_t unread_q, unread_d;
  occ_t occ_q, occ_d;
  logic out_valid_q, out_valid_d;

  logic push, pop, re;

  // Handshakes and read issue; in_ready comes only from the occ register.
  always_comb begin
    bus.in_ready = (occ_q != occ_t'(DEPTH));
    push         = bus.in_valid & bus.in_ready;
    pop          = out_valid_q & bus.out_ready;
    re           = ((unread_q != '0) | push) & (~out_valid_q | pop);
  end

  // Next-state for pointers, counters and head-valid flag.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d    = re   ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    unread_d    = unread_q + occ_t'(push) - occ_t'(re);
    occ_d       = occ_q + occ_t'(push) - occ_t'(pop);
    out_valid_d = re ? 1'b1 : (pop ? 1'b0 : out_valid_q);
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      unread_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      unread_q    <= unread_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.occ       = occ_q;

  sa_ram_rws_64x18 u_ram (
    .clk           (clk),
    .we            (push),
    .wa            (wr_ptr_q),
    .di            (bus.in_data),
    .re            (re),
    .ra            (rd_ptr_q),
    .dout          (bus.out_data),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: tb/tb_sa_fifo_flowctl_64x18.sv
// Bench for sa_fifo_flowctl_64x18: directed stimulus plus a negedge monitor that
// records accepted words into a queue and checks every pop and the occupancy.
module tb_sa_fifo_flowctl_64x18;
  import sa_fifo_flowctl_64x18_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pwrbus_ram_pd = 32'h0;

  sa_fifo_flowctl_64x18_if bus ();

  sa_fifo_flowctl_64x18 dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  data_t exp_q[$];
  int    model_occ = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare pops against the queue, track occupancy, record pushes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_occ = 0;
    end else begin
      check("mon_occ", 32'(bus.occ), 32'(model_occ));
      check("mon_in_ready", 32'(bus.in_ready), 32'(model_occ != 64));
      check("mon_out_valid", 32'(bus.out_valid), 32'(model_occ != 0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("mon_pop_empty", 32'(1), 32'(0));
        else check("mon_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        model_occ--;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        model_occ++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && cyc < 200) begin
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check({name, "_drained"}, 32'(bus.out_valid), 32'(0));
    check({name, "_occ0"}, 32'(bus.occ), 32'(0));
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int accepted;
    int cyc;
    data_t word;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_occ", 32'(bus.occ), 32'(0));
    check("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));

    // Single word: falls through in one cycle and holds under backpressure.
    bus.in_valid = 1'b1;
    bus.in_data  = 18'h2A5A5;
    step();
    bus.in_valid = 1'b0;
    check("single_valid", 32'(bus.out_valid), 32'(1));
    check("single_data", 32'(bus.out_data), 32'h2A5A5);
    check("single_occ", 32'(bus.occ), 32'(1));
    for (int i = 0; i < 10; i++) begin
      step();
      check("single_hold", 32'(bus.out_data), 32'h2A5A5);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("single_pop_occ", 32'(bus.occ), 32'(0));
    check("single_pop_valid", 32'(bus.out_valid), 32'(0));

    // Fill to 64, then a rejected push attempt.
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = data_t'(i);
      step();
    end
    check("fill_occ", 32'(bus.occ), 32'(64));
    check("fill_in_ready", 32'(bus.in_ready), 32'(0));
    bus.in_data = 18'h3FFFF;
    step();
    check("full_push_ignored", 32'(bus.occ), 32'(64));
    check("full_head", 32'(bus.out_data), 32'(0));

    // Pop and push together while full: only the pop takes effect.
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("fullpop_occ", 32'(bus.occ), 32'(63));
    check("fullpop_in_ready", 32'(bus.in_ready), 32'(1));
    check("fullpop_next_head", 32'(bus.out_data), 32'(1));
    drain("fill");

    // Streaming: one in, one out every cycle, occupancy pinned at 1.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.in_data = data_t'(18'h100 + i);
      step();
      check("stream_occ", 32'(bus.occ), 32'(1));
      check("stream_data", 32'(bus.out_data), 32'(18'h100 + i));
    end
    drain("stream");

    // Random valid/ready, 2000 accepted words.
    accepted = 0;
    cyc = 0;
    word = 18'h1000;
    while (accepted < 2000 && cyc < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = word;
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        word = word + 18'd1;
      end
      step();
      cyc++;
    end
    check("random_accepted", 32'(accepted), 32'(2000));
    drain("random");

    // Reset mid-stream with 20 held words.
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = data_t'(18'h2000 + i);
      step();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_occ", 32'(bus.occ), 32'(20));
    check("pre_rst_valid", 32'(bus.out_valid), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_occ", 32'(bus.occ), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = 18'h00001;
    step();
    bus.in_valid = 1'b0;
    check("post_rst_valid", 32'(bus.out_valid), 32'(1));
    check("post_rst_data", 32'(bus.out_data), 32'h00001);
    drain("post_rst");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
